// File: rtl/pong_renderer.sv
// Pong game state (paddles, ball, scores, serve/play/game-over) and the RGB332 pixel stage
// that sits directly behind the 640x480 video timer. Game state advances once per frame.
module pong_renderer #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int BALL_SPEED     = 2,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 48,
  parameter int PADDLE_STEP    = 4,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SERVE_FRAMES   = 60,
  parameter int WIN_SCORE      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  input  logic       btn_start,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] rgb,
  output logic [3:0] score_l,
  output logic [3:0] score_r
);

  typedef enum logic [1:0] {
    SERVE    = 2'd0,
    PLAY     = 2'd1,
    GAMEOVER = 2'd2
  } state_e;

  localparam int SC_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] BALL_SZ    = 10'(BALL_SIZE);
  localparam logic [9:0] BALL_SPD   = 10'(BALL_SPEED);
  localparam logic [9:0] PAD_W      = 10'(PADDLE_W);
  localparam logic [9:0] PAD_H      = 10'(PADDLE_H);
  localparam logic [9:0] PAD_STEP   = 10'(PADDLE_STEP);
  localparam logic [9:0] LPAD_X     = 10'(LEFT_PADDLE_X);
  localparam logic [9:0] RPAD_X     = 10'(RIGHT_PADDLE_X);
  localparam logic [9:0] LEFT_FACE  = 10'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [9:0] RIGHT_FACE = 10'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [9:0] BY_MAX     = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] BY_TURN    = 10'(V_ACTIVE - BALL_SIZE - BALL_SPEED);
  localparam logic [9:0] BX_MISS    = 10'(H_ACTIVE - BALL_SIZE - BALL_SPEED);
  localparam logic [9:0] PAD_Y_MAX  = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] PAD_Y0     = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] BALL_X0    = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BALL_Y0    = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] NET_X0     = 10'(H_ACTIVE / 2 - 2);
  localparam logic [9:0] NET_X1     = 10'(H_ACTIVE / 2 + 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_FRAMES - 1);

  state_e          state_q, state_d;
  logic [9:0]      bx_q, bx_d, by_q, by_d;
  logic [9:0]      ly_q, ly_d, ry_q, ry_d;
  logic            dx_q, dx_d, dy_q, dy_d;   // 1 = moving toward larger coordinate
  logic [3:0]      score_l_q, score_l_d, score_r_q, score_r_d;
  logic [SC_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [7:0]      rgb_q, rgb_d;

  logic       tick;
  logic [3:0] score_l_inc, score_r_inc;
  logic       in_ball, in_lpad, in_rpad, in_net;

  // Saturating paddle move; the bound check precedes the subtraction so y never wraps.
  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up,
                                             input logic dn);
    logic [9:0] r;
    r = y;
    if (up && !dn) begin
      r = (y < PAD_STEP) ? '0 : y - PAD_STEP;
    end else if (dn && !up) begin
      r = (y > PAD_Y_MAX - PAD_STEP) ? PAD_Y_MAX : y + PAD_STEP;
    end
    return r;
  endfunction

  function automatic logic overlaps(input logic [9:0] ball_y, input logic [9:0] pad_y);
    return (ball_y + BALL_SZ > pad_y) && (ball_y < pad_y + PAD_H);
  endfunction

  assign tick        = (xpos == '0) && (ypos == V_ACT);
  assign score_l_inc = score_l_q + 4'd1;
  assign score_r_inc = score_r_q + 4'd1;

  assign hsync_out = hsync_in;
  assign vsync_out = vsync_in;
  assign rgb       = rgb_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned
    // (which would infer a latch).
    state_d     = state_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    ly_d        = ly_q;
    ry_d        = ry_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_cnt_d = serve_cnt_q;

    if (tick) begin
      ly_d = paddle_next(ly_q, btn_l_up, btn_l_dn);
      ry_d = paddle_next(ry_q, btn_r_up, btn_r_dn);

      case (state_q)
        SERVE: begin
          bx_d = BALL_X0;
          by_d = BALL_Y0;
          if (serve_cnt_q == SERVE_LAST) begin
            serve_cnt_d = '0;
            state_d     = PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + SC_W'(1);
          end
        end

        PLAY: begin
          if (!dy_q && by_q <= BALL_SPD) begin
            by_d = '0;
            dy_d = 1'b1;
          end else if (dy_q && by_q >= BY_TURN) begin
            by_d = BY_MAX;
            dy_d = 1'b0;
          end else if (dy_q) begin
            by_d = by_q + BALL_SPD;
          end else begin
            by_d = by_q - BALL_SPD;
          end

          // Bounce windows are one step wide in front of each face, so a ball already
          // behind a face can never be caught by a paddle moving onto it.
          if (!dx_q && bx_q >= LEFT_FACE && bx_q < LEFT_FACE + BALL_SPD &&
              overlaps(by_q, ly_q)) begin
            bx_d = LEFT_FACE;
            dx_d = 1'b1;
          end else if (dx_q && bx_q <= RIGHT_FACE && bx_q > RIGHT_FACE - BALL_SPD &&
                       overlaps(by_q, ry_q)) begin
            bx_d = RIGHT_FACE;
            dx_d = 1'b0;
          end else if (!dx_q && bx_q <= BALL_SPD) begin
            score_r_d = score_r_inc;
            dx_d      = 1'b0;
            bx_d      = BALL_X0;
            by_d      = BALL_Y0;
            state_d   = (score_r_inc == WIN) ? GAMEOVER : SERVE;
          end else if (dx_q && bx_q >= BX_MISS) begin
            score_l_d = score_l_inc;
            dx_d      = 1'b1;
            bx_d      = BALL_X0;
            by_d      = BALL_Y0;
            state_d   = (score_l_inc == WIN) ? GAMEOVER : SERVE;
          end else if (dx_q) begin
            bx_d = bx_q + BALL_SPD;
          end else begin
            bx_d = bx_q - BALL_SPD;
          end
        end

        GAMEOVER: begin
          if (btn_start) begin
            score_l_d   = '0;
            score_r_d   = '0;
            bx_d        = BALL_X0;
            by_d        = BALL_Y0;
            serve_cnt_d = '0;
            state_d     = SERVE;
          end
        end

        default: state_d = SERVE;
      endcase
    end
  end

  assign in_ball = (state_q != GAMEOVER) &&
                   (xpos >= bx_q) && (xpos < bx_q + BALL_SZ) &&
                   (ypos >= by_q) && (ypos < by_q + BALL_SZ);
  assign in_lpad = (xpos >= LPAD_X) && (xpos < LPAD_X + PAD_W) &&
                   (ypos >= ly_q) && (ypos < ly_q + PAD_H);
  assign in_rpad = (xpos >= RPAD_X) && (xpos < RPAD_X + PAD_W) &&
                   (ypos >= ry_q) && (ypos < ry_q + PAD_H);
  assign in_net  = (xpos >= NET_X0) && (xpos <= NET_X1) && !ypos[3];

  always_comb begin
    rgb_d = 8'h00;
    if (xpos >= H_ACT || ypos >= V_ACT) begin
      rgb_d = 8'h00;
    end else if (in_ball) begin
      rgb_d = 8'hFF;
    end else if (in_lpad) begin
      rgb_d = 8'hE0;
    end else if (in_rpad) begin
      rgb_d = 8'h03;
    end else if (in_net) begin
      rgb_d = 8'h92;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SERVE;
      bx_q        <= BALL_X0;
      by_q        <= BALL_Y0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      ly_q        <= PAD_Y0;
      ry_q        <= PAD_Y0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_cnt_q <= '0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      ly_q        <= ly_d;
      ry_q        <= ry_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_cnt_q <= serve_cnt_d;
      rgb_q       <= rgb_d;
    end
  end

endmodule

// File: tb/tb_pong_renderer.sv
// Self-checking bench for pong_renderer: a compressed timer drives frame ticks and pixel probes,
// and every observed pixel/score is compared against an integer game model of the rules.
module tb_pong_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] xpos = '0;
  logic [9:0] ypos = '0;
  logic       hsync_in = 1'b1, vsync_in = 1'b1;
  logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
  logic       btn_start = 1'b0;
  logic       hsync_out, vsync_out;
  logic [7:0] rgb;
  logic [3:0] score_l, score_r;

  pong_renderer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .xpos      (xpos),
    .ypos      (ypos),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .btn_l_up  (btn_l_up),
    .btn_l_dn  (btn_l_dn),
    .btn_r_up  (btn_r_up),
    .btn_r_dn  (btn_r_dn),
    .btn_start (btn_start),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .rgb       (rgb),
    .score_l   (score_l),
    .score_r   (score_r)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Game model: signed velocities and plain integer geometry.
  typedef enum int {M_SERVE, M_PLAY, M_OVER} mphase_e;
  int      m_bx, m_by, m_vx, m_vy, m_ly, m_ry, m_sl, m_sr, m_cnt;
  mphase_e m_ph;

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2;
    m_ly = 216; m_ry = 216; m_sl = 0; m_sr = 0; m_cnt = 0;
    m_ph = M_SERVE;
  endtask

  function automatic int move_paddle(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 432) ? 432 : y + 4;
    return y;
  endfunction

  function automatic bit hits(input int y, input int py);
    return (y + 8 > py) && (y < py + 48);
  endfunction

  task automatic point_to(input bit left_won);
    if (left_won) begin m_sl++; m_vx = 2; end
    else begin m_sr++; m_vx = -2; end
    m_bx = 316; m_by = 236;
    m_ph = (m_sl == 9 || m_sr == 9) ? M_OVER : M_SERVE;
  endtask

  task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd,
                            input bit st);
    int oly, ory, oby, ny;
    oly = m_ly; ory = m_ry; oby = m_by;
    m_ly = move_paddle(m_ly, lu, ld);
    m_ry = move_paddle(m_ry, ru, rd);
    case (m_ph)
      M_SERVE: begin
        if (m_cnt == 59) begin m_cnt = 0; m_ph = M_PLAY; end
        else m_cnt++;
      end
      M_PLAY: begin
        ny = m_by + m_vy;
        if (ny <= 0) begin m_by = 0; m_vy = 2; end
        else if (ny >= 472) begin m_by = 472; m_vy = -2; end
        else m_by = ny;
        if (m_vx < 0 && m_bx >= 24 && m_bx < 26 && hits(oby, oly)) begin
          m_bx = 24; m_vx = 2;
        end else if (m_vx > 0 && m_bx <= 608 && m_bx > 606 && hits(oby, ory)) begin
          m_bx = 608; m_vx = -2;
        end else if (m_vx < 0 && m_bx + m_vx <= 0) begin
          point_to(1'b0);
        end else if (m_vx > 0 && m_bx + m_vx + 8 >= 640) begin
          point_to(1'b1);
        end else begin
          m_bx = m_bx + m_vx;
        end
      end
      default: begin
        if (st) begin
          m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_cnt = 0; m_ph = M_SERVE;
        end
      end
    endcase
  endtask

  function automatic logic [7:0] exp_pix(input int x, input int y);
    if (x >= 640 || y >= 480) return 8'h00;
    if (m_ph != M_OVER && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 8'hFF;
    if (x >= 16 && x < 24 && y >= m_ly && y < m_ly + 48) return 8'hE0;
    if (x >= 616 && x < 624 && y >= m_ry && y < m_ry + 48) return 8'h03;
    if (x >= 318 && x <= 321 && (y / 8) % 2 == 0) return 8'h92;
    return 8'h00;
  endfunction

  task automatic drive(input int x, input int y);
    @(negedge clk);
    xpos = 10'(x);
    ypos = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y);
    if (x < 0 || y < 0 || (x == 0 && y == 480)) return;
    drive(x, y);
    check($sformatf("pix(%0d,%0d)", x, y), rgb, exp_pix(x, y));
  endtask

  task automatic tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
    @(negedge clk);
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd; btn_start = st;
    xpos = 10'd0; ypos = 10'd480;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    #1;
    check("hsync_pass", hsync_out, hsync_in);
    check("vsync_pass", vsync_out, vsync_in);
    @(posedge clk);
    #1;
    model_tick(lu, ld, ru, rd, st);
    check("score_l", score_l, m_sl);
    check("score_r", score_r, m_sr);
  endtask

  task automatic frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
    tick(lu, ld, ru, rd, st);
    probe(m_bx, m_by);
    probe(m_bx + 7, m_by + 7);
    probe(m_bx - 1, m_by + 3);
    probe(m_bx + 8, m_by + 4);
    probe(20, m_ly - 1);
    probe(20, m_ly + 47);
    probe(620, m_ry);
    probe(620, m_ry + 48);
    probe($urandom_range(0, 799), $urandom_range(0, 524));
  endtask

  initial begin
    model_reset();

    // Reset state.
    drive(316, 236);
    check("rst_rgb", rgb, 8'h00);
    check("rst_score_l", score_l, 4'd0);
    check("rst_score_r", score_r, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two idle frames: ball held at centre, blank beyond the active area.
    frame(0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0);
    probe(316, 236);
    probe(323, 243);
    probe(700, 100);
    probe(100, 500);

    // Left paddle driven to the top, then both left buttons together.
    for (int f = 0; f < 60; f++) frame(1, 0, 0, 0, 0);
    probe(16, 0);
    for (int f = 0; f < 4; f++) frame(1, 1, 0, 0, 0);

    // Rally play: right tracks while left is lazy, then left tracks while right parks at top.
    for (int f = 0; f < 5000 && m_ph != M_OVER; f++) begin
      bit lu, ld, ru, rd, st;
      lu = 0; ld = 0; ru = 0; rd = 0;
      if (m_sr >= 2) begin
        lu = (m_ly + 24 > m_by + 8);
        ld = (m_ly + 24 < m_by);
        ru = 1;
      end else begin
        ru = (m_ry + 24 > m_by + 8);
        rd = (m_ry + 24 < m_by);
      end
      if ($urandom_range(0, 15) == 0) begin
        lu = 1'($urandom); ld = 1'($urandom);
      end
      st = ($urandom_range(0, 49) == 0);
      frame(lu, ld, ru, rd, st);
    end
    check("final_score", (score_l > score_r) ? score_l : score_r, 4'd9);

    // Game over: ball hidden, scores frozen, start only counts at a tick.
    for (int f = 0; f < 3; f++) frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    btn_start = 1'b1;
    probe(316, 236);
    probe(320, 240);
    btn_start = 1'b0;
    check("over_score_l_hold", score_l, m_sl);
    check("over_score_r_hold", score_r, m_sr);
    frame(0, 0, 0, 0, 1);
    for (int f = 0; f < 3; f++) frame(0, 0, 0, 0, 0);

    // Reset mid-line during play.
    for (int f = 0; f < 80 && m_ph != M_PLAY; f++) frame(0, 0, 0, 0, 0);
    for (int f = 0; f < 5; f++) frame(0, 0, 0, 0, 0);
    probe(m_bx + 2, m_by + 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midline_rst_rgb", rgb, 8'h00);
    check("midline_rst_score_l", score_l, 4'd0);
    check("midline_rst_score_r", score_r, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 64; f++) frame(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
